// File: rtl/user_mgr_arbiter.sv
// rtl/user_mgr_arbiter.sv - shares one user-domain OBI manager port between NumMgr managers
// Optional USER_MGR_ARB_FIXED_PRIO_EN: lowest requesting index wins instead of round-robin.

package user_mgr_arbiter_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_t;

  typedef struct packed {
    mgr_obi_a_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    mgr_obi_r_t r;
  } mgr_obi_rsp_t;

endpackage

module user_mgr_arbiter
  import user_mgr_arbiter_pkg::*;
#(
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mgr_obi_req_t mgr_req_i [NumMgr],
  output mgr_obi_rsp_t mgr_rsp_o [NumMgr],
  output mgr_obi_req_t user_mgr_obi_req_o,
  input  mgr_obi_rsp_t user_mgr_obi_rsp_i,
  output logic         busy_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [IdxW-1:0] winner;
  logic            win_req;
  logic            can_issue;
  logic            handshake;
  logic            rsp_take;
  logic [IdxW-1:0] head_idx;

  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef USER_MGR_ARB_FIXED_PRIO_EN
  always_comb begin
    winner  = '0;
    win_req = 1'b0;
    if (lock_q) begin
      winner  = lock_idx_q;
      win_req = mgr_req_i[lock_idx_q].a.req;
    end else begin
      // Descending scan so the last hit is the lowest requesting index.
      for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
        if (mgr_req_i[i].a.req) begin
          winner  = IdxW'(i);
          win_req = 1'b1;
        end
      end
    end
  end
`else
  logic [IdxW-1:0] rr_ptr_q;

  always_comb begin
    logic [IdxW:0] cand;
    winner  = '0;
    win_req = 1'b0;
    cand    = '0;
    if (lock_q) begin
      winner  = lock_idx_q;
      win_req = mgr_req_i[lock_idx_q].a.req;
    end else begin
      for (int i = 0; i < int'(NumMgr); i++) begin
        cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
        if (cand >= (IdxW + 1)'(NumMgr)) cand = cand - (IdxW + 1)'(NumMgr);
        if (!win_req && mgr_req_i[cand[IdxW-1:0]].a.req) begin
          winner  = cand[IdxW-1:0];
          win_req = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= (winner == IdxW'(NumMgr - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  // The limit looks only at the registered count, so a response frees a slot one cycle later.
  assign can_issue = (count_q != CntW'(MaxTrans));
  assign handshake = user_mgr_obi_req_o.a.req & user_mgr_obi_rsp_i.gnt;
  assign rsp_take  = user_mgr_obi_rsp_i.rvalid & (count_q != '0);
  assign head_idx  = fifo_q[rd_ptr_q];
  assign busy_o    = (count_q != '0) | user_mgr_obi_req_o.a.req;

  always_comb begin
    user_mgr_obi_req_o = '0;
    if (win_req && can_issue) begin
      user_mgr_obi_req_o.a = mgr_req_i[winner].a;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NumMgr); i++) begin
      mgr_rsp_o[i]     = '0;
      mgr_rsp_o[i].gnt = handshake && (winner == IdxW'(i));
      if (rsp_take && (head_idx == IdxW'(i))) begin
        mgr_rsp_o[i].rvalid = 1'b1;
        mgr_rsp_o[i].r      = user_mgr_obi_rsp_i.r;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(MaxTrans); i++) fifo_q[i] <= '0;
    end else begin
      // A presented-but-stalled request pins the selection until it is granted.
      lock_q <= user_mgr_obi_req_o.a.req & ~user_mgr_obi_rsp_i.gnt;
      if (user_mgr_obi_req_o.a.req && !user_mgr_obi_rsp_i.gnt) lock_idx_q <= winner;
      if (handshake) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (rsp_take) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (handshake && !rsp_take)      count_q <= count_q + 1'b1;
      else if (!handshake && rsp_take) count_q <= count_q - 1'b1;
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    user_mgr_obi_rsp_i.rvalid |-> (count_q != '0))
    else $warning("user_mgr_arbiter: rvalid with no outstanding transaction dropped");

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    handshake |-> (count_q != CntW'(MaxTrans)))
    else $error("user_mgr_arbiter: grant with index FIFO full");
`endif

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// tb/tb_user_mgr_arbiter.sv - self-checking bench for user_mgr_arbiter
module tb_user_mgr_arbiter;
  import user_mgr_arbiter_pkg::*;

`ifdef USER_MGR_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  typedef struct {
    bit r0;
    bit r1;
    bit g;
    bit rv;
    int exp_w;
    bit perr;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  mgr_obi_req_t mgr_req [2];
  mgr_obi_rsp_t mgr_rsp [2];
  mgr_obi_req_t req_out;
  mgr_obi_rsp_t rsp_in;
  logic         busy;

  exp_rsp_t     sb[$];
  logic [31:0]  next_rdata;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk_i = ~clk_i;

  user_mgr_arbiter #(.NumMgr(2), .MaxTrans(2)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .mgr_req_i          (mgr_req),
    .mgr_rsp_o          (mgr_rsp),
    .user_mgr_obi_req_o (req_out),
    .user_mgr_obi_rsp_i (rsp_in),
    .busy_o             (busy)
  );

  function automatic logic [31:0] addr_of(input int i);
    return (i == 0) ? 32'h0000_1000 : 32'h0000_2000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mgr_req[0].a.req = 1'b0;
    mgr_req[1].a.req = 1'b0;
    rsp_in = '0;
  endtask

  task automatic cycle(input bit r0, input bit r1, input bit g, input bit rv,
                       input int exp_w, input bit perr);
    exp_rsp_t e;
    exp_rsp_t n;
    bit       have;
    bit       hit;
    @(posedge clk_i);
    #2;
    mgr_req[0].a.req = r0;
    mgr_req[1].a.req = r1;
    have = (sb.size() != 0);
    if (have) begin
      e = sb[0];
    end else begin
      e.idx   = -1;
      e.rdata = 32'hBAD0_0BAD;
      e.err   = 1'b1;
    end
    rsp_in.gnt     = g;
    rsp_in.rvalid  = rv;
    rsp_in.r.rdata = rv ? e.rdata : 32'h0;
    rsp_in.r.err   = rv & e.err;
    #1;
    chk("a_req", req_out.a.req, exp_w >= 0);
    chk("a_addr", req_out.a.addr, (exp_w >= 0) ? addr_of(exp_w) : 32'h0);
    chk("a_we", req_out.a.we, exp_w == 1);
    for (int i = 0; i < 2; i++) begin
      hit = rv && have && (e.idx == i);
      chk($sformatf("gnt%0d", i), mgr_rsp[i].gnt, g && (exp_w == i));
      chk($sformatf("rvalid%0d", i), mgr_rsp[i].rvalid, hit);
      chk($sformatf("rdata%0d", i), mgr_rsp[i].r.rdata, hit ? e.rdata : 32'h0);
      chk($sformatf("err%0d", i), mgr_rsp[i].r.err, hit && e.err);
    end
    if (rv && have) void'(sb.pop_front());
    if (g && exp_w >= 0) begin
      n.idx   = exp_w;
      n.rdata = next_rdata;
      n.err   = perr;
      sb.push_back(n);
      next_rdata = next_rdata + 32'h0101_0101;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, FP ? 0 : 1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 0,          1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, FP ? 0 : 1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 0,          1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, -1,         1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, -1,         1'b0};

    for (int i = 0; i < 2; i++) begin
      mgr_req[i]         = '0;
      mgr_req[i].a.addr  = addr_of(i);
      mgr_req[i].a.we    = (i == 1);
      mgr_req[i].a.be    = 4'hF;
      mgr_req[i].a.wdata = 32'h1111_0000 + i;
    end
    idle_inputs();
    next_rdata = 32'h0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_req", req_out.a.req, 1'b0);
    chk("rst_gnt0", mgr_rsp[0].gnt, 1'b0);
    chk("rst_rvalid1", mgr_rsp[1].rvalid, 1'b0);
    rst_ni = 1'b1;

    // Single read from manager 0
    next_rdata = 32'hCAFE_F00D;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("single_busy_c0", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("single_busy_c1", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
    chk("single_busy_c3", busy, 1'b0);

    // Continuous requests from both managers, overlapping responses
    for (int k = 0; k < 6; k++)
      cycle(tbl[k].r0, tbl[k].r1, tbl[k].g, tbl[k].rv, tbl[k].exp_w, tbl[k].perr);
    chk("table_busy_end", busy, 1'b0);

    // Stalled request stays locked on manager 0 while the pointer favours manager 1
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Outstanding limit: two handshakes then a.req drops until a slot frees
    cycle(1'b1, 1'b1, 1'b1, 1'b0, FP ? 0 : 1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    chk("limit_busy", busy, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, FP ? 0 : 1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("limit_busy_end", busy, 1'b0);

    // Reset with two outstanding, then a stray response
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, FP ? 0 : 1, 1'b0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    idle_inputs();
    sb.delete();
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rvalid0", mgr_rsp[0].rvalid, 1'b0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    chk("stray_busy", busy, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("post_rst_busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("final_busy", busy, 1'b0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/user_mgr_arbiter.md
Name: user_mgr_arbiter

Overview:
- Shares the single user-domain OBI manager port (toward the Croc subordinate crossbar) between NumMgr user managers, e.g. the SHA-2 engine's fetch DMA plus a future accelerator.
- Arbitrates address phases round-robin and tracks outstanding transactions in order.
- Routes each response back to the manager that issued it.
- Sits in user_domain between the user managers and the user_mgr_obi_req_o / user_mgr_obi_rsp_i pair.

Parameters:
- NumMgr, 2, number of requesting managers (2..8).
- MaxTrans, 2, maximum outstanding transactions on the shared port (1..8).
- IdxW, derived, max(1, clog2(NumMgr)); do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mgr_req_i  in  NumMgr x mgr_obi_req_t  per-manager OBI request (a.req, a.addr, a.we, a.be, a.wdata).
- mgr_rsp_o  out  NumMgr x mgr_obi_rsp_t  per-manager OBI response (gnt, rvalid, r.rdata, r.err).
- user_mgr_obi_req_o  out  mgr_obi_req_t  shared request toward the crossbar.
- user_mgr_obi_rsp_i  in  mgr_obi_rsp_t  shared response from the crossbar.
- busy_o  out  1  high while any transaction is outstanding or a request is presented downstream.

Behaviour:
- Reset values: user_mgr_obi_req_o all-zero; all mgr_rsp_o zero; busy_o 0; round-robin pointer 0; outstanding count 0; index FIFO empty; lock clear.
- Arbitration (combinational, same cycle):
  - The winner is the first requesting index at or after rr_ptr, wrapping modulo NumMgr.
  - The winner's a-channel fields are muxed onto user_mgr_obi_req_o.
  - Only the winner sees gnt = downstream gnt. All others see gnt = 0.
- Lock:
  - If downstream a.req=1 and gnt=0, the lock register captures the winner index.
  - While locked, the same index stays selected whatever other requests arrive. This is an OBI stability requirement.
  - Lock clears on the cycle gnt=1.
- Pointer update: on a granted handshake from index k, rr_ptr <= (k+1) mod NumMgr. rr_ptr is unchanged when nothing is granted.
- Outstanding limit:
  - When count == MaxTrans, downstream a.req is forced 0 and no gnt is forwarded.
  - A response arriving in that cycle frees a slot on the next cycle only. There is no combinational rvalid-to-req path.
- Index FIFO: depth MaxTrans, width IdxW.
  - Push: winner index on each downstream handshake.
  - Pop: on user_mgr_obi_rsp_i.rvalid.
  - Response routing: rvalid, rdata and err go to the FIFO head index. All other managers see rvalid = 0 and rdata = 0.
- Counter arithmetic:
  - count +1 on handshake only; -1 on rvalid only; unchanged when both occur in the same cycle.
  - Pointers wrap modulo MaxTrans.
- Boundary conditions:
  - rvalid with an empty FIFO: ignored, nothing routed, count stays 0. A simulation-only assertion fires.
  - Grant with a full FIFO: impossible by the outstanding limit; asserted.
  - NumMgr == 1: degenerates to a pass-through with tracking. The FIFO content is always 0.
- Latency: zero-cycle request path (combinational mux). Response path also zero cycles (combinational demux on the FIFO head).
- Reset mid-transaction: all state clears immediately. Responses still in flight afterwards hit the empty-FIFO rule and are dropped.
- busy_o = (count != 0) | user_mgr_obi_req_o.a.req.

Optional Feature:
- Macro: USER_MGR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest requesting index wins. rr_ptr and its update logic are removed. Lock behaviour and outstanding tracking are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Single manager 0 read of addr 0x0000_1000, downstream gnt in the same cycle, rvalid 2 cycles later with rdata 0xCAFE_F00D -> mgr0 sees gnt at cycle 0 and rvalid+rdata at cycle 2; mgr1 sees nothing; busy_o high for cycles 0-1 and low at cycle 3.
- Both managers request continuously, gnt always 1, rvalid 1 cycle later -> grants alternate 0,1,0,1. Each response goes to its issuer. With USER_MGR_ARB_FIXED_PRIO_EN defined, all grants go to 0.
- Downstream gnt held 0 for 3 cycles while mgr0 is presented, then mgr1 raises req -> output stays on mgr0 with addr stable, and mgr0 is granted on the 4th cycle.
- MaxTrans=2, gnt=1, rvalid held off -> after 2 handshakes a.req drops to 0. The first rvalid re-enables a.req on the next cycle, and the responses return to their issuers in order (0 then 1).
- Handshake and rvalid in the same cycle with count=1 -> count stays 1; the FIFO pushes and pops correctly; the error response (err=1) reaches the correct manager.
- Assert rst_ni low with 2 outstanding, release, then inject a stray rvalid -> no manager sees rvalid; count=0; the next request is granted normally.
